// File: rtl/mf_trig_pkg.sv
// Shared types and helpers for the matched-filter SIMD trigger.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: trigger state enum, lane geometry, signed lane saturation.
package mf_trig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_TRACK,
    ST_REPORT,
    ST_HOLDOFF
  } trig_state_e;

  localparam int LANE_BITS = 24;
  localparam int NLANES    = 2;

  // Clamp a signed 24-bit lane into the signed range of 'outbits'. The result
  // keeps 24 bits; the caller narrows it. Wider outputs pass through.
  function automatic logic signed [LANE_BITS-1:0] sat_lane(
    input logic signed [LANE_BITS-1:0] x,
    input int                          outbits
  );
    int v;
    int hi;
    int lo;
    v  = int'(x);
    hi = (1 << (outbits - 1)) - 1;
    lo = -hi - 1;
    if (outbits >= LANE_BITS) return x;
    if (v > hi) return LANE_BITS'(hi);
    if (v < lo) return LANE_BITS'(lo);
    return x;
  endfunction

endpackage

// File: rtl/mf_lane_sat.sv
// Saturates one signed 24-bit filter lane to OUTBITS signed.
// Latency: 1 clock (registered output).
// Backpressure: none; a new sample is accepted every clock.
// Ports: clk_i/rst_i clock and sync active-high reset, lane_i raw lane,
//        sat_o saturated lane.
module mf_lane_sat
  import mf_trig_pkg::*;
#(
  parameter int OUTBITS = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [LANE_BITS-1:0] lane_i,
  output logic [OUTBITS-1:0]   sat_o
);

  logic signed [LANE_BITS-1:0] clip;
  logic [OUTBITS-1:0]          sat_d;
  logic [OUTBITS-1:0]          sat_q;

  always_comb begin
    clip  = sat_lane(signed'(lane_i), OUTBITS);
    // clip already lies in range, so narrowing (or sign-extending) is exact
    sat_d = OUTBITS'(clip);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sat_q <= '0;
    else       sat_q <= sat_d;
  end

  assign sat_o = sat_q;

endmodule

// File: rtl/mf_simd_trigger.sv
// Threshold trigger on the packed two-lane filter output: reports excursion peaks.
// Latency: state decision 2 clocks after dat_i; trig_valid_o 3 clocks after the end pair.
// Backpressure: report held on trig_valid_o until trig_ready_i; input ignored meanwhile.
// Ports: clk_i/rst_i clock and sync active-high reset; dat_i packed lanes
//        (lane0 = [23:0] older); enable_i arm level; thresh_i signed threshold;
//        holdoff_i post-report dead time; trig_* report handshake and payload.
module mf_simd_trigger
  import mf_trig_pkg::*;
#(
  parameter int OUTBITS  = 16,
  parameter int TSBITS   = 32,
  parameter int HOLDBITS = 16,
  parameter int MAXLEN   = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [LANE_BITS*NLANES-1:0]   dat_i,
  input  logic                          enable_i,
  input  logic [OUTBITS-1:0]            thresh_i,
  input  logic [HOLDBITS-1:0]           holdoff_i,
  output logic                          trig_valid_o,
  input  logic                          trig_ready_i,
  output logic [OUTBITS-1:0]            trig_peak_o,
  output logic                          trig_lane_o,
  output logic [TSBITS-1:0]             trig_time_o
);

  localparam int              CNTW     = $clog2(MAXLEN + 1);
  localparam logic [CNTW-1:0] MAXLEN_C = CNTW'(MAXLEN);

  // Timestamp and input pipeline
  logic [TSBITS-1:0]           ts_q;
  logic [LANE_BITS*NLANES-1:0] s1_dat_q;
  logic [TSBITS-1:0]           s1_ts_q;
  logic [TSBITS-1:0]           s2_ts_q;
  logic signed [OUTBITS-1:0]   sat0;
  logic signed [OUTBITS-1:0]   sat1;

  // Trigger state
  trig_state_e               state_q;
  logic                      valid_q;
  logic signed [OUTBITS-1:0] peak_q;
  logic                      lane_q;
  logic [TSBITS-1:0]         time_q;
  logic [CNTW-1:0]           cnt_q;
  logic [HOLDBITS-1:0]       hold_q;

  // Per-pair decision terms
  logic                      over0;
  logic                      over1;
  logic                      any_over;
  logic                      pick1;
  logic signed [OUTBITS-1:0] best_val;
  logic                      beats;
  logic [CNTW-1:0]           cnt_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_q     <= '0;
      s1_dat_q <= '0;
      s1_ts_q  <= '0;
      s2_ts_q  <= '0;
    end else begin
      ts_q     <= ts_q + TSBITS'(1);
      s1_dat_q <= dat_i;
      s1_ts_q  <= ts_q;
      s2_ts_q  <= s1_ts_q;
    end
  end

  mf_lane_sat #(.OUTBITS(OUTBITS)) u_sat0 (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .lane_i (s1_dat_q[LANE_BITS-1:0]),
    .sat_o  (sat0)
  );

  mf_lane_sat #(.OUTBITS(OUTBITS)) u_sat1 (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .lane_i (s1_dat_q[2*LANE_BITS-1:LANE_BITS]),
    .sat_o  (sat1)
  );

  always_comb begin
    over0    = sat0 >= $signed(thresh_i);
    over1    = sat1 >= $signed(thresh_i);
    any_over = over0 || over1;
    // Best over sample of the pair. Lane1 wins only when strictly larger, which
    // matches scanning lane0 then lane1 with a strictly-greater update rule.
    pick1    = over1 && (!over0 || (sat1 > sat0));
    best_val = pick1 ? sat1 : sat0;
    beats    = any_over && (best_val > peak_q);
    cnt_nxt  = cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      peak_q  <= '0;
      lane_q  <= 1'b0;
      time_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable_i) state_q <= ST_ARMED;
        end

        ST_ARMED: begin
          if (!enable_i) begin
            state_q <= ST_IDLE;
          end else if (any_over) begin
            peak_q <= best_val;
            lane_q <= pick1;
            time_q <= s2_ts_q;
            // The triggering pair is the first tracked sample
            cnt_q  <= CNTW'(1);
            if (MAXLEN == 1) begin
              state_q <= ST_REPORT;
              valid_q <= 1'b1;
            end else begin
              state_q <= ST_TRACK;
            end
          end
        end

        ST_TRACK: begin
          if (beats) begin
            peak_q <= best_val;
            lane_q <= pick1;
            time_q <= s2_ts_q;
          end
          cnt_q <= cnt_nxt;
          if (!any_over || (cnt_nxt == MAXLEN_C)) begin
            state_q <= ST_REPORT;
            valid_q <= 1'b1;
          end
        end

        ST_REPORT: begin
          if (trig_ready_i) begin
            valid_q <= 1'b0;
            hold_q  <= holdoff_i;
            if (holdoff_i == '0) state_q <= enable_i ? ST_ARMED : ST_IDLE;
            else                 state_q <= ST_HOLDOFF;
          end
        end

        ST_HOLDOFF: begin
          hold_q <= hold_q - HOLDBITS'(1);
          if (hold_q == HOLDBITS'(1)) state_q <= enable_i ? ST_ARMED : ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign trig_valid_o = valid_q;
  assign trig_peak_o  = peak_q;
  assign trig_lane_o  = lane_q;
  assign trig_time_o  = time_q;

endmodule

// File: tb/tb_mf_simd_trigger.sv
// Directed bench for mf_simd_trigger: reset, pulse, tie/saturation,
// backpressure/holdoff, MAXLEN forcing and enable handling.
module tb_mf_simd_trigger;

  localparam int OUTBITS  = 16;
  localparam int TSBITS   = 32;
  localparam int HOLDBITS = 16;
  localparam int MAXLEN   = 4;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [47:0]         dat_i;
  logic                enable_i;
  logic [OUTBITS-1:0]  thresh_i;
  logic [HOLDBITS-1:0] holdoff_i;
  logic                trig_valid_o;
  logic                trig_ready_i;
  logic [OUTBITS-1:0]  trig_peak_o;
  logic                trig_lane_o;
  logic [TSBITS-1:0]   trig_time_o;

  logic [31:0] cyc;
  int checks = 0;
  int errors = 0;

  mf_simd_trigger #(
    .OUTBITS (OUTBITS),
    .TSBITS  (TSBITS),
    .HOLDBITS(HOLDBITS),
    .MAXLEN  (MAXLEN)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .dat_i        (dat_i),
    .enable_i     (enable_i),
    .thresh_i     (thresh_i),
    .holdoff_i    (holdoff_i),
    .trig_valid_o (trig_valid_o),
    .trig_ready_i (trig_ready_i),
    .trig_peak_o  (trig_peak_o),
    .trig_lane_o  (trig_lane_o),
    .trig_time_o  (trig_time_o)
  );

  always #5 clk_i = ~clk_i;

  // Bench clock count: cycle index since the last reset edge
  always @(posedge clk_i) cyc <= rst_i ? 32'd0 : cyc + 32'd1;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic put(input int l0, input int l1);
    dat_i = {l1[23:0], l0[23:0]};
  endtask

  task automatic wait_valid(input int budget, output int n, output bit seen);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < budget) begin
      if (trig_valid_o) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    bit seen;
    int cnt;
    rst_i = 1'b1; enable_i = 1'b0; trig_ready_i = 1'b1; holdoff_i = '0;
    thresh_i = 16'd100; put(0, 0);
    tick(3);
    rst_i = 1'b0; enable_i = 1'b1; put(700, 0);
    tick(4);
    rst_i = 1'b1;
    tick(3);
    checks++; if (trig_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", trig_valid_o); end
    checks++; if (trig_peak_o !== 16'd0) begin errors++; $display("FAIL reset_peak got %0d want 0", trig_peak_o); end
    checks++; if (trig_lane_o !== 1'b0) begin errors++; $display("FAIL reset_lane got %b want 0", trig_lane_o); end
    checks++; if (trig_time_o !== 32'd0) begin errors++; $display("FAIL reset_time got %0d want 0", trig_time_o); end
    // release: this cycle carries timestamp 0
    rst_i = 1'b0; put(500, 0);
    tick();
    put(0, 0);
    wait_valid(10, n, seen);
    checks++; if (!seen || n != 3) begin errors++; $display("FAIL release_latency seen %b waited %0d want 1/3", seen, n); end
    checks++; if (trig_peak_o !== 16'd500) begin errors++; $display("FAIL release_peak got %0d want 500", trig_peak_o); end
    checks++; if (trig_time_o !== 32'd0) begin errors++; $display("FAIL release_time got %0d want 0", trig_time_o); end
    tick();
    checks++; if (trig_valid_o !== 1'b0) begin errors++; $display("FAIL release_drop got %b want 0", trig_valid_o); end
    // reset in REPORT drops the pending report
    trig_ready_i = 1'b0; put(400, 0);
    tick();
    put(0, 0);
    wait_valid(10, n, seen);
    checks++; if (!seen) begin errors++; $display("FAIL report_pending got 0 want 1"); end
    rst_i = 1'b1;
    tick();
    checks++; if (trig_valid_o !== 1'b0) begin errors++; $display("FAIL report_reset got %b want 0", trig_valid_o); end
    rst_i = 1'b0; trig_ready_i = 1'b1;
    cnt = 0;
    repeat (8) begin tick(); if (trig_valid_o) cnt++; end
    checks++; if (cnt != 0) begin errors++; $display("FAIL report_dropped valid cycles %0d want 0", cnt); end
  endtask

  task automatic test_basic_pulse();
    logic [31:0] t300;
    logic [31:0] c40;
    int n;
    bit seen;
    int cnt;
    put(0, 0); tick(4);
    put(50, 0);  tick();
    put(120, 0); tick();
    put(300, 0); t300 = cyc; tick();
    put(200, 0); tick();
    put(40, 0);  c40 = cyc; tick();
    put(0, 0);
    wait_valid(10, n, seen);
    checks++; if (!seen || cyc !== c40 + 32'd3) begin errors++; $display("FAIL basic_rise seen %b at %0d want %0d", seen, cyc, c40 + 32'd3); end
    checks++; if (trig_peak_o !== 16'd300) begin errors++; $display("FAIL basic_peak got %0d want 300", trig_peak_o); end
    checks++; if (trig_lane_o !== 1'b0) begin errors++; $display("FAIL basic_lane got %b want 0", trig_lane_o); end
    checks++; if (trig_time_o !== t300) begin errors++; $display("FAIL basic_time got %0d want %0d", trig_time_o, t300); end
    tick();
    cnt = 0;
    repeat (8) begin tick(); if (trig_valid_o) cnt++; end
    checks++; if (cnt != 0) begin errors++; $display("FAIL basic_single extra valid cycles %0d want 0", cnt); end
  endtask

  task automatic test_tie_sat();
    int n;
    bit seen;
    int cnt;
    put(32'h7FFFFF, 32'h7FFFFF); tick();
    put(0, 0);
    wait_valid(10, n, seen);
    checks++; if (!seen || trig_peak_o !== 16'h7FFF) begin errors++; $display("FAIL tie_peak seen %b got %0h want 7fff", seen, trig_peak_o); end
    checks++; if (trig_lane_o !== 1'b0) begin errors++; $display("FAIL tie_lane got %b want 0", trig_lane_o); end
    tick();
    put(32'h800000, -5); tick(3);
    thresh_i = 16'd0;
    cnt = 0;
    repeat (8) begin tick(); if (trig_valid_o) cnt++; end
    checks++; if (cnt != 0) begin errors++; $display("FAIL sat_negative valid cycles %0d want 0", cnt); end
    put(32'h800000, 40000); tick();
    put(-1, -1);
    wait_valid(10, n, seen);
    checks++; if (!seen || trig_peak_o !== 16'h7FFF) begin errors++; $display("FAIL sat_peak seen %b got %0h want 7fff", seen, trig_peak_o); end
    checks++; if (trig_lane_o !== 1'b1) begin errors++; $display("FAIL sat_lane got %b want 1", trig_lane_o); end
    tick(3);
    thresh_i = 16'd100;
  endtask

  task automatic test_backpressure();
    logic [31:0] t600;
    logic [31:0] texp;
    int n;
    bit seen;
    put(0, 0); tick(3);
    holdoff_i = 16'd5; trig_ready_i = 1'b0;
    put(600, 0); t600 = cyc; tick();
    put(0, 0);
    wait_valid(10, n, seen);
    checks++; if (!seen) begin errors++; $display("FAIL bp_report got 0 want 1"); end
    for (int i = 0; i < 10; i++) begin
      put((i >= 2 && i < 7) ? 900 : 0, (i >= 2 && i < 7) ? 900 : 0);
      tick();
      checks++;
      if (trig_valid_o !== 1'b1 || trig_peak_o !== 16'd600 || trig_time_o !== t600) begin
        errors++;
        $display("FAIL bp_hold_%0d valid %b peak %0d time %0d want 1/600/%0d", i, trig_valid_o, trig_peak_o, trig_time_o, t600);
      end
    end
    trig_ready_i = 1'b1; put(0, 0);
    tick();
    checks++; if (trig_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drop got %b want 0", trig_valid_o); end
    // decreasing values so the captured peak names the first armed pair
    for (int j = 0; j < 8; j++) begin
      put(2000 - 10 * j, 0);
      if (j == 3) texp = cyc;
      tick();
    end
    put(0, 0);
    wait_valid(10, n, seen);
    holdoff_i = '0;
    checks++; if (!seen || trig_peak_o !== 16'd1970) begin errors++; $display("FAIL rearm_peak seen %b got %0d want 1970", seen, trig_peak_o); end
    checks++; if (trig_time_o !== texp) begin errors++; $display("FAIL rearm_time got %0d want %0d", trig_time_o, texp); end
  endtask

  task automatic test_maxlen();
    logic [31:0] c0;
    logic [31:0] rise [3];
    logic [31:0] tm [3];
    logic [15:0] pk [3];
    int nrep;
    for (int i = 0; i < 3; i++) begin rise[i] = '0; tm[i] = '0; pk[i] = '0; end
    put(0, 0); tick(12);
    put(500, 0); c0 = cyc;
    nrep = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (trig_valid_o && nrep < 3) begin
        rise[nrep] = cyc; tm[nrep] = trig_time_o; pk[nrep] = trig_peak_o;
        nrep++;
      end
    end
    checks++; if (nrep != 3) begin errors++; $display("FAIL maxlen_count got %0d want 3", nrep); end
    checks++; if (rise[0] !== c0 + 32'd6) begin errors++; $display("FAIL maxlen_first got %0d want %0d", rise[0], c0 + 32'd6); end
    checks++; if (rise[1] - rise[0] !== 32'd5) begin errors++; $display("FAIL maxlen_period1 got %0d want 5", rise[1] - rise[0]); end
    checks++; if (rise[2] - rise[1] !== 32'd5) begin errors++; $display("FAIL maxlen_period2 got %0d want 5", rise[2] - rise[1]); end
    checks++; if (tm[0] !== c0) begin errors++; $display("FAIL maxlen_time0 got %0d want %0d", tm[0], c0); end
    checks++; if (tm[1] !== c0 + 32'd5) begin errors++; $display("FAIL maxlen_time1 got %0d want %0d", tm[1], c0 + 32'd5); end
    checks++; if (pk[1] !== 16'd500) begin errors++; $display("FAIL maxlen_peak got %0d want 500", pk[1]); end
    put(0, 0); tick(8);
  endtask

  task automatic test_disable();
    int n;
    bit seen;
    int cnt;
    enable_i = 1'b0; tick(2);
    put(800, 0); tick(3);
    put(0, 0);
    cnt = 0;
    repeat (8) begin tick(); if (trig_valid_o) cnt++; end
    checks++; if (cnt != 0) begin errors++; $display("FAIL idle_ignore valid cycles %0d want 0", cnt); end
    enable_i = 1'b1; tick(2);
    put(700, 0); tick();
    put(750, 0); tick();
    put(0, 0);   tick();
    enable_i = 1'b0;
    wait_valid(10, n, seen);
    checks++; if (!seen || trig_peak_o !== 16'd750) begin errors++; $display("FAIL track_disable seen %b peak %0d want 1/750", seen, trig_peak_o); end
    tick();
    put(900, 0);
    cnt = 0;
    repeat (8) begin tick(); if (trig_valid_o) cnt++; end
    checks++; if (cnt != 0) begin errors++; $display("FAIL disable_idle valid cycles %0d want 0", cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_pulse();
    test_tie_sat();
    test_backpressure();
    test_maxlen();
    test_disable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
